inst_loader: RTL and testbench

//  Program loader upstream of the processor top. Receives a byte stream over a valid/ready port.

---
 rtl/inst_loader.sv | 136 +++++++++++++
 tb/tb_inst_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream program loader writing big-endian words to instruction memory
// Optional checksum byte after the last word: define INST_LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int WORD = 32,
    parameter int ADDR = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR:0]     len_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ADDR-1:0]   mem_addr_o,
    output logic [WORD-1:0]   mem_data_o,
    output logic              mem_write_o,
    output logic              core_run_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam logic [ADDR:0] DEPTH_W = (ADDR+1)'(1 << ADDR);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t          state_q;
    logic [ADDR:0]   len_q;
    logic [ADDR:0]   wcnt_q;
    logic [1:0]      bcnt_q;
    logic [WORD-1:0] sh_q;
    logic [ADDR-1:0] addr_q;
    logic [WORD-1:0] data_q;
    logic            done_q;

    logic [WORD-1:0] word_d;
    logic [ADDR:0]   wcnt_d;

    assign word_d = {sh_q[WORD-9:0], byte_i};
    assign wcnt_d = wcnt_q + (ADDR+1)'(1);

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_d;
    assign sum_d = sum_q + byte_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            // done/core_run trail entry into DONE by one cycle and drop on the start edge
            done_q <= (state_q == S_DONE) && !start_i;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        if (len_i == '0 || len_i > DEPTH_W) begin
                            state_q <= S_ERR;
                        end else begin
                            len_q   <= len_i;
                            wcnt_q  <= '0;
                            bcnt_q  <= '0;
                            sh_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                            sum_q   <= '0;
`endif
                            state_q <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid_i) begin
                        sh_q   <= word_d;
                        bcnt_q <= bcnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        sum_q  <= sum_d;
`endif
                        if (bcnt_q == 2'd3) begin
                            addr_q  <= wcnt_q[ADDR-1:0];
                            data_q  <= word_d;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wcnt_q <= wcnt_d;
                    if (wcnt_d == len_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                        state_q <= S_CHECK;
`else
                        state_q <= S_DONE;
`endif
                    end else begin
                        state_q <= S_RECV;
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid_i) begin
                        state_q <= (sum_d == 8'h00) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    assign byte_ready_o = (state_q == S_RECV) || (state_q == S_CHECK);
    assign busy_o       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
    assign byte_ready_o = (state_q == S_RECV);
    assign busy_o       = (state_q == S_RECV) || (state_q == S_WRITE);
`endif
    assign mem_write_o  = (state_q == S_WRITE);
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign done_o       = done_q;
    assign core_run_o   = done_q;
    assign err_o        = (state_q == S_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - scoreboard bench for inst_loader
module tb_inst_loader;
    localparam int ADDR = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic [ADDR:0]   len_i;
    logic [7:0]      byte_i;
    logic            byte_valid_i;
    logic            byte_ready_o;
    logic [ADDR-1:0] mem_addr_o;
    logic [31:0]     mem_data_o;
    logic            mem_write_o;
    logic            core_run_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    inst_loader #(.WORD(32), .ADDR(ADDR)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_write_o(mem_write_o),
        .core_run_o(core_run_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  nvec = 0;
    int  nerr = 0;
    int  writes = 0;

    always @(negedge clk) begin
        if (!reset && mem_write_o) begin
            writes++;
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write addr=%h data=%h required=none", mem_addr_o, mem_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr_o !== e.a || mem_data_o !== e.d) begin
                    nerr++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             mem_addr_o, mem_data_o, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int l);
        start_i = 1'b1;
        len_i   = (ADDR+1)'(l);
        tick();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int guard = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 0, 1);
        tick();
        byte_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done_o && !err_o && n < budget) begin
            tick();
            n++;
        end
        chk(name, {62'd0, done_o, err_o}, 64'd2);
    endtask

    int w0;

    initial begin
        reset = 1'b1; start_i = 1'b0; len_i = '0; byte_i = '0; byte_valid_i = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", {mem_addr_o, mem_data_o, mem_write_o, core_run_o, busy_o,
                              done_o, err_o, byte_ready_o}, 64'd0);
        reset = 1'b0;
        tick();

        // 1: two words, valid every cycle, latency of done
        w0 = writes;
        push(8'h00, 32'h12345678);
        push(8'h01, 32'h9ABCDEF0);
        start(2);
        chk("t1_busy", busy_o, 1);
        send_word(32'h12345678, 0);
        send_word(32'h9ABCDEF0, 0);
        chk("t1_done_n", done_o, 0);
        tick();
        chk("t1_done_n1", done_o, 0);
        tick();
        chk("t1_done_n2", {done_o, core_run_o, busy_o}, 64'b110);
        chk("t1_writes", writes - w0, 2);

        // 2: same stream with gaps; restart from DONE
        w0 = writes;
        push(8'h00, 32'h12345678);
        push(8'h01, 32'h9ABCDEF0);
        start(2);
        chk("t2_done_drop", {done_o, core_run_o}, 0);
        send_word(32'h12345678, 2);
        send_word(32'h9ABCDEF0, 2);
        wait_done("t2_done", 20);
        chk("t2_writes", writes - w0, 2);

        // 3: illegal lengths
        w0 = writes;
        start(0);
        chk("t3_len0_err", {err_o, done_o, core_run_o, busy_o}, 64'b1000);
        byte_valid_i = 1'b1;
        byte_i = 8'h55;
        repeat (3) begin
            tick();
            chk("t3_ready_low", byte_ready_o, 0);
        end
        byte_valid_i = 1'b0;
        start(257);
        chk("t3_len257_err", {err_o, byte_ready_o}, 64'b10);
        repeat (2) tick();
        chk("t3_writes", writes - w0, 0);

        // 4: reset after two of four words, then reload one word
        push(8'h00, 32'h01020304);
        push(8'h01, 32'h05060708);
        start(4);
        send_word(32'h01020304, 0);
        send_word(32'h05060708, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t4_reset_outputs", {mem_addr_o, mem_data_o, mem_write_o, core_run_o, busy_o,
                                 done_o, err_o, byte_ready_o}, 64'd0);
        reset = 1'b0;
        tick();
        w0 = writes;
        push(8'h00, 32'hAABBCCDD);
        start(1);
        send_word(32'hAABBCCDD, 0);
        wait_done("t4_done", 20);
        chk("t4_writes", writes - w0, 1);

        // 5: full depth with random data
        w0 = writes;
        start(256);
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = $urandom;
            push(8'(i), w);
            send_word(w, 0);
            if (i == 128) chk("t5_midway_done", done_o, 0);
        end
        wait_done("t5_done", 20);
        repeat (5) tick();
        chk("t5_writes", writes - w0, 256);
        chk("t5_busy", busy_o, 0);

`ifdef INST_LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        push(8'h00, 32'h01020304);
        start(1);
        send_word(32'h01020304, 0);
        tick();
        chk("t6_check_ready", byte_ready_o, 1);
        send(8'hF6, 0);
        wait_done("t6_chk_good", 20);
        push(8'h00, 32'h01020304);
        start(1);
        send_word(32'h01020304, 0);
        send(8'hF7, 0);
        chk("t6_chk_bad", {err_o, core_run_o, done_o}, 64'b100);
`endif

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
